// File: rtl/fifo_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_if
// Handshake bundle between a FIFO producer/consumer (master) and the FIFO
// pointer/flag controller (slave).
//   master drives : wr_req, rd_req, err_clr
//   slave drives  : fifo_wenable, fifo_renable, write_ptr, read_ptr,
//                   fifo_count, fifo_full, fifo_empty, fifo_threshold,
//                   overflow_err, underflow_err
// PTR_SIZE must match the PTR_SIZE of the fifo_ctrl instance it connects to.
// -----------------------------------------------------------------------------
interface fifo_ctrl_if #(
  parameter int PTR_SIZE = 3
);
  logic                wr_req;
  logic                rd_req;
  logic                err_clr;
  logic                fifo_wenable;
  logic                fifo_renable;
  logic [PTR_SIZE-1:0] write_ptr;
  logic [PTR_SIZE-1:0] read_ptr;
  logic [PTR_SIZE:0]   fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_threshold;
  logic                overflow_err;
  logic                underflow_err;

  modport master (
    output wr_req, rd_req, err_clr,
    input  fifo_wenable, fifo_renable, write_ptr, read_ptr, fifo_count,
           fifo_full, fifo_empty, fifo_threshold, overflow_err, underflow_err
  );

  modport slave (
    input  wr_req, rd_req, err_clr,
    output fifo_wenable, fifo_renable, write_ptr, read_ptr, fifo_count,
           fifo_full, fifo_empty, fifo_threshold, overflow_err, underflow_err
  );
endinterface

// File: rtl/fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl
// Pointer, occupancy and error-flag controller for an external FIFO storage
// array of OSTD_NUM entries (any depth >= 2, not restricted to powers of two).
//   clk_in  : single clock, rising edge
//   areset  : asynchronous active-high reset
//   bus     : fifo_ctrl_if.slave
//             in : wr_req, rd_req, err_clr
//             out: fifo_wenable/fifo_renable (combinational accept strobes),
//                  write_ptr/read_ptr, fifo_count (registered),
//                  fifo_full/fifo_empty/fifo_threshold (decoded from count),
//                  overflow_err/underflow_err (sticky)
// -----------------------------------------------------------------------------
module fifo_ctrl #(
  parameter int OSTD_NUM        = 8,
  parameter int THRESHOLD_VALUE = OSTD_NUM / 2,
  parameter int PTR_SIZE        = (OSTD_NUM > 1) ? $clog2(OSTD_NUM) : 1
) (
  input  logic      clk_in,
  input  logic      areset,
  fifo_ctrl_if.slave bus
);

  localparam int                  CNT_W    = PTR_SIZE + 1;
  localparam logic [PTR_SIZE-1:0] PTR_LAST = PTR_SIZE'(OSTD_NUM - 1);
  localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(OSTD_NUM);
  localparam logic [CNT_W-1:0]    CNT_THR  = CNT_W'(THRESHOLD_VALUE);

  // Explicit wrap keeps non-power-of-two depths inside 0..OSTD_NUM-1.
  function automatic logic [PTR_SIZE-1:0] ptr_inc(input logic [PTR_SIZE-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_SIZE'(1);
  endfunction

  logic [PTR_SIZE-1:0] wptr_q, wptr_d;
  logic [PTR_SIZE-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;

  logic full, empty, wr_acc, rd_acc;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // No empty bypass: a pop needs a stored entry. A push into a full FIFO
  // succeeds only when a pop frees a slot in the same cycle. Strobes are
  // held low while reset is asserted.
  assign rd_acc = bus.rd_req & ~empty & ~areset;
  assign wr_acc = bus.wr_req & (~full | rd_acc) & ~areset;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_acc) wptr_d = ptr_inc(wptr_q);
    if (rd_acc) rptr_d = ptr_inc(rptr_q);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Set has priority over clear so a fault in the clearing cycle is kept.
    ovf_d = (ovf_q & ~bus.err_clr) | (bus.wr_req & ~wr_acc);
    udf_d = (udf_q & ~bus.err_clr) | (bus.rd_req & ~rd_acc);
  end

  always_ff @(posedge clk_in or posedge areset) begin
    if (areset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign bus.fifo_wenable   = wr_acc;
  assign bus.fifo_renable   = rd_acc;
  assign bus.write_ptr      = wptr_q;
  assign bus.read_ptr       = rptr_q;
  assign bus.fifo_count     = count_q;
  assign bus.fifo_full      = full;
  assign bus.fifo_empty     = empty;
  assign bus.fifo_threshold = (count_q >= CNT_THR);
  assign bus.overflow_err   = ovf_q;
  assign bus.underflow_err  = udf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_ctrl
// Directed bench for fifo_ctrl: an 8-deep instance (threshold 4) and a
// 6-deep instance exercising non-power-of-two pointer wrap.
// -----------------------------------------------------------------------------
module tb_fifo_ctrl;

  logic clk_in;
  logic areset;

  fifo_ctrl_if #(.PTR_SIZE(3)) if8 ();
  fifo_ctrl_if #(.PTR_SIZE(3)) if6 ();

  fifo_ctrl #(.OSTD_NUM(8), .THRESHOLD_VALUE(4), .PTR_SIZE(3)) dut8 (
    .clk_in (clk_in),
    .areset (areset),
    .bus    (if8)
  );

  fifo_ctrl #(.OSTD_NUM(6), .THRESHOLD_VALUE(3), .PTR_SIZE(3)) dut6 (
    .clk_in (clk_in),
    .areset (areset),
    .bus    (if6)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset;
    areset = 1'b1;
    if8.wr_req = 1'b1; if8.rd_req = 1'b1; if8.err_clr = 1'b0;
    if6.wr_req = 1'b0; if6.rd_req = 1'b0; if6.err_clr = 1'b0;
    #2;
    n_cmp++; if (if8.fifo_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", if8.fifo_count); end
    n_cmp++; if (if8.fifo_empty !== 1'b1 || if8.fifo_full !== 1'b0 || if8.fifo_threshold !== 1'b0) begin n_fail++; $display("FAIL reset_flags got e/f/t=%b%b%b exp=100", if8.fifo_empty, if8.fifo_full, if8.fifo_threshold); end
    n_cmp++; if (if8.write_ptr !== 3'd0 || if8.read_ptr !== 3'd0) begin n_fail++; $display("FAIL reset_ptrs got w=%0d r=%0d exp=0/0", if8.write_ptr, if8.read_ptr); end
    n_cmp++; if (if8.overflow_err !== 1'b0 || if8.underflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_errs got o=%b u=%b exp=0/0", if8.overflow_err, if8.underflow_err); end
    n_cmp++; if (if8.fifo_wenable !== 1'b0 || if8.fifo_renable !== 1'b0) begin n_fail++; $display("FAIL reset_enables got we=%b re=%b exp=0/0", if8.fifo_wenable, if8.fifo_renable); end
    tick;
    n_cmp++; if (if8.fifo_count !== 4'd0 || if8.write_ptr !== 3'd0) begin n_fail++; $display("FAIL reset_hold got cnt=%0d w=%0d exp=0/0", if8.fifo_count, if8.write_ptr); end
    if8.wr_req = 1'b0; if8.rd_req = 1'b0;
    #3;
    areset = 1'b0;
    tick;
  endtask

  task automatic test_fill;
    for (int i = 0; i < 8; i++) begin
      if8.wr_req = 1'b1;
      #1;
      n_cmp++; if (if8.fifo_wenable !== 1'b1 || if8.write_ptr !== 3'(i)) begin n_fail++; $display("FAIL fill_we[%0d] got we=%b w=%0d exp=1/%0d", i, if8.fifo_wenable, if8.write_ptr, i); end
      tick;
      n_cmp++; if (if8.fifo_count !== 4'(i + 1)) begin n_fail++; $display("FAIL fill_cnt[%0d] got=%0d exp=%0d", i, if8.fifo_count, i + 1); end
      n_cmp++; if (if8.fifo_threshold !== ((i + 1) >= 4) || if8.fifo_full !== (i == 7) || if8.fifo_empty !== 1'b0) begin n_fail++; $display("FAIL fill_flags[%0d] got t/f/e=%b%b%b", i, if8.fifo_threshold, if8.fifo_full, if8.fifo_empty); end
    end
    if8.wr_req = 1'b0;
    n_cmp++; if (if8.write_ptr !== 3'd0 || if8.read_ptr !== 3'd0) begin n_fail++; $display("FAIL fill_wrap got w=%0d r=%0d exp=0/0", if8.write_ptr, if8.read_ptr); end
  endtask

  task automatic test_overflow;
    if8.wr_req = 1'b1;
    #1;
    n_cmp++; if (if8.fifo_wenable !== 1'b0) begin n_fail++; $display("FAIL ovf_we got=%b exp=0", if8.fifo_wenable); end
    tick;
    if8.wr_req = 1'b0;
    n_cmp++; if (if8.overflow_err !== 1'b1 || if8.fifo_count !== 4'd8 || if8.write_ptr !== 3'd0) begin n_fail++; $display("FAIL ovf_set got o=%b cnt=%0d w=%0d exp=1/8/0", if8.overflow_err, if8.fifo_count, if8.write_ptr); end
    tick;
    n_cmp++; if (if8.overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", if8.overflow_err); end
    // clear and a new overflow in the same cycle: set wins
    if8.err_clr = 1'b1; if8.wr_req = 1'b1;
    tick;
    n_cmp++; if (if8.overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got=%b exp=1", if8.overflow_err); end
    if8.wr_req = 1'b0;
    tick;
    if8.err_clr = 1'b0;
    n_cmp++; if (if8.overflow_err !== 1'b0 || if8.underflow_err !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got o=%b u=%b exp=0/0", if8.overflow_err, if8.underflow_err); end
  endtask

  task automatic test_full_rw;
    for (int i = 0; i < 3; i++) begin
      if8.wr_req = 1'b1; if8.rd_req = 1'b1;
      #1;
      n_cmp++; if (if8.fifo_wenable !== 1'b1 || if8.fifo_renable !== 1'b1) begin n_fail++; $display("FAIL full_rw_en[%0d] got we=%b re=%b exp=1/1", i, if8.fifo_wenable, if8.fifo_renable); end
      tick;
      n_cmp++; if (if8.fifo_count !== 4'd8 || if8.overflow_err !== 1'b0) begin n_fail++; $display("FAIL full_rw_cnt[%0d] got cnt=%0d o=%b exp=8/0", i, if8.fifo_count, if8.overflow_err); end
    end
    if8.wr_req = 1'b0; if8.rd_req = 1'b0;
    n_cmp++; if (if8.write_ptr !== 3'd3 || if8.read_ptr !== 3'd3) begin n_fail++; $display("FAIL full_rw_ptrs got w=%0d r=%0d exp=3/3", if8.write_ptr, if8.read_ptr); end
  endtask

  task automatic test_drain;
    for (int i = 0; i < 8; i++) begin
      if8.rd_req = 1'b1;
      tick;
      n_cmp++; if (if8.fifo_count !== 4'(7 - i) || if8.fifo_threshold !== ((7 - i) >= 4)) begin n_fail++; $display("FAIL drain[%0d] got cnt=%0d t=%b exp=%0d", i, if8.fifo_count, if8.fifo_threshold, 7 - i); end
    end
    n_cmp++; if (if8.read_ptr !== 3'd3 || if8.fifo_empty !== 1'b1) begin n_fail++; $display("FAIL drain_end got r=%0d e=%b exp=3/1", if8.read_ptr, if8.fifo_empty); end
    #1;
    n_cmp++; if (if8.fifo_renable !== 1'b0) begin n_fail++; $display("FAIL udf_re got=%b exp=0", if8.fifo_renable); end
    tick;
    if8.rd_req = 1'b0;
    n_cmp++; if (if8.underflow_err !== 1'b1 || if8.fifo_count !== 4'd0 || if8.read_ptr !== 3'd3) begin n_fail++; $display("FAIL udf_set got u=%b cnt=%0d r=%0d exp=1/0/3", if8.underflow_err, if8.fifo_count, if8.read_ptr); end
    if8.err_clr = 1'b1;
    tick;
    if8.err_clr = 1'b0;
    n_cmp++; if (if8.underflow_err !== 1'b0) begin n_fail++; $display("FAIL udf_clr got=%b exp=0", if8.underflow_err); end
  endtask

  task automatic test_empty_rw;
    if8.wr_req = 1'b1; if8.rd_req = 1'b1;
    #1;
    n_cmp++; if (if8.fifo_wenable !== 1'b1 || if8.fifo_renable !== 1'b0) begin n_fail++; $display("FAIL empty_rw_en got we=%b re=%b exp=1/0", if8.fifo_wenable, if8.fifo_renable); end
    tick;
    if8.wr_req = 1'b0; if8.rd_req = 1'b0;
    n_cmp++; if (if8.underflow_err !== 1'b1 || if8.fifo_count !== 4'd1) begin n_fail++; $display("FAIL empty_rw got u=%b cnt=%0d exp=1/1", if8.underflow_err, if8.fifo_count); end
    n_cmp++; if (if8.write_ptr !== 3'd4 || if8.read_ptr !== 3'd3) begin n_fail++; $display("FAIL empty_rw_ptrs got w=%0d r=%0d exp=4/3", if8.write_ptr, if8.read_ptr); end
  endtask

  task automatic test_async_reset;
    if8.wr_req = 1'b1;
    repeat (4) tick;
    if8.wr_req = 1'b0;
    n_cmp++; if (if8.fifo_count !== 4'd5 || if8.write_ptr !== 3'd0 || if8.read_ptr !== 3'd3) begin n_fail++; $display("FAIL pre_areset got cnt=%0d w=%0d r=%0d exp=5/0/3", if8.fifo_count, if8.write_ptr, if8.read_ptr); end
    #1;
    areset = 1'b1;
    #1;
    n_cmp++; if (if8.fifo_count !== 4'd0 || if8.fifo_empty !== 1'b1 || if8.read_ptr !== 3'd0 || if8.underflow_err !== 1'b0) begin n_fail++; $display("FAIL areset_async got cnt=%0d e=%b r=%0d u=%b exp=0/1/0/0", if8.fifo_count, if8.fifo_empty, if8.read_ptr, if8.underflow_err); end
    #1;
    areset = 1'b0;
    tick;
    n_cmp++; if (if8.fifo_count !== 4'd0 || if8.write_ptr !== 3'd0) begin n_fail++; $display("FAIL areset_after got cnt=%0d w=%0d exp=0/0", if8.fifo_count, if8.write_ptr); end
  endtask

  task automatic test_depth6;
    int exp_w = 0;
    int exp_r = 0;
    for (int i = 0; i < 10; i++) begin
      if6.wr_req = 1'b1;
      #1;
      n_cmp++; if (if6.fifo_wenable !== 1'b1 || if6.write_ptr !== 3'(exp_w)) begin n_fail++; $display("FAIL d6_push[%0d] got we=%b w=%0d exp=1/%0d", i, if6.fifo_wenable, if6.write_ptr, exp_w); end
      tick;
      if6.wr_req = 1'b0;
      exp_w = (exp_w + 1) % 6;
      n_cmp++; if (if6.fifo_count !== 4'd1 || if6.write_ptr !== 3'(exp_w)) begin n_fail++; $display("FAIL d6_after_push[%0d] got cnt=%0d w=%0d exp=1/%0d", i, if6.fifo_count, if6.write_ptr, exp_w); end
      if6.rd_req = 1'b1;
      #1;
      n_cmp++; if (if6.fifo_renable !== 1'b1 || if6.read_ptr !== 3'(exp_r)) begin n_fail++; $display("FAIL d6_pop[%0d] got re=%b r=%0d exp=1/%0d", i, if6.fifo_renable, if6.read_ptr, exp_r); end
      tick;
      if6.rd_req = 1'b0;
      exp_r = (exp_r + 1) % 6;
      n_cmp++; if (if6.fifo_count !== 4'd0 || if6.read_ptr !== 3'(exp_r)) begin n_fail++; $display("FAIL d6_after_pop[%0d] got cnt=%0d r=%0d exp=0/%0d", i, if6.fifo_count, if6.read_ptr, exp_r); end
    end
    n_cmp++; if (if6.write_ptr !== 3'd4 || if6.read_ptr !== 3'd4 || if6.fifo_empty !== 1'b1) begin n_fail++; $display("FAIL d6_final got w=%0d r=%0d e=%b exp=4/4/1", if6.write_ptr, if6.read_ptr, if6.fifo_empty); end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_overflow;
    test_full_rw;
    test_drain;
    test_empty_rw;
    test_async_reset;
    test_depth6;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter OSTD_NUM, default 8: FIFO depth in entries; legal range >= 2; need not be a power of two.
REQ-002 Parameter THRESHOLD_VALUE, default OSTD_NUM/2: occupancy at or above which fifo_threshold asserts; legal range 1..OSTD_NUM.
REQ-003 Parameter PTR_SIZE, default (OSTD_NUM > 1) ? $clog2(OSTD_NUM) : 1: pointer width.
REQ-004 clk_in  input  1: the single clock; all state updates on its rising edge.
REQ-005 areset  input  1: asynchronous, active-high reset.
REQ-006 wr_req  input  1: producer requests a push this cycle.
REQ-007 rd_req  input  1: consumer requests a pop this cycle.
REQ-008 err_clr  input  1: clears both sticky error flags.
REQ-009 fifo_wenable  output  1: write strobe to the storage array; high only in cycles where a push is accepted.
REQ-010 fifo_renable  output  1: read strobe to the storage array; high only in cycles where a pop is accepted.
REQ-011 write_ptr  output  PTR_SIZE: storage index written by the current accepted push.
REQ-012 read_ptr  output  PTR_SIZE: storage index of the oldest entry, read by the current accepted pop.
REQ-013 fifo_count  output  PTR_SIZE+1: current occupancy, 0..OSTD_NUM.
REQ-014 fifo_full, fifo_empty, fifo_threshold  output  1 each: occupancy flags.
REQ-015 overflow_err, underflow_err  output  1 each: sticky error flags.

Function
REQ-016 Pop accepted (rd_acc) SHALL equal rd_req AND NOT fifo_empty; there is no empty-FIFO bypass, so a pop in the same cycle as a push into an empty FIFO is rejected.
REQ-017 Push accepted (wr_acc) SHALL equal wr_req AND (NOT fifo_full OR rd_acc); a push into a full FIFO is accepted only when a pop is accepted in the same cycle.
REQ-018 fifo_wenable SHALL equal wr_acc and fifo_renable SHALL equal rd_acc, both combinational in the same cycle as the request, with zero latency.
REQ-019 write_ptr and read_ptr SHALL be registers that advance by 1 on the clock edge ending a cycle in which wr_acc or rd_acc, respectively, is high.
REQ-020 Each pointer SHALL wrap from OSTD_NUM-1 to 0; values >= OSTD_NUM never occur, including for depths that are not a power of two.
REQ-021 fifo_count SHALL be a register updated on each edge as follows: wr_acc only -> +1; rd_acc only -> -1; both or neither -> unchanged.
REQ-022 fifo_full SHALL equal (fifo_count == OSTD_NUM), decoded combinationally from the registered count.
REQ-023 fifo_empty SHALL equal (fifo_count == 0), decoded combinationally from the registered count.
REQ-024 fifo_threshold SHALL equal (fifo_count >= THRESHOLD_VALUE), decoded combinationally from the registered count.
REQ-025 overflow_err SHALL set on the edge after any cycle with wr_req high and wr_acc low, and SHALL stay set until cleared.
REQ-026 underflow_err SHALL set on the edge after any cycle with rd_req high and rd_acc low, and SHALL stay set until cleared.
REQ-027 err_clr high SHALL clear both error flags on the next edge; if a set condition occurs in the same cycle, the set wins.
REQ-028 Rejected requests SHALL leave pointers and count unchanged.
REQ-029 Pointer and count arithmetic SHALL never under- or overflow its register width.

Reset
REQ-030 While areset is high, asynchronously and independent of clk_in: write_ptr=0, read_ptr=0, fifo_count=0, overflow_err=0, underflow_err=0; hence fifo_empty=1, fifo_full=0, fifo_threshold=0.
REQ-031 While areset is high, fifo_wenable and fifo_renable SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard the occupancy immediately; storage contents are not cleared by this block.
REQ-033 After areset deasserts, the first accepted request SHALL occur no earlier than the first rising edge of clk_in.

Verification (OSTD_NUM=8, THRESHOLD_VALUE=4)
REQ-034 Reset, then 8 consecutive wr_req -> write_ptr 0..7 then 0, fifo_threshold rises after the 4th push, fifo_full=1 after the 8th push, fifo_count=8.
REQ-035 From full, wr_req alone -> fifo_wenable=0, overflow_err=1 next cycle, count stays 8; then err_clr -> overflow_err=0.
REQ-036 From full, wr_req and rd_req together for 3 cycles -> both enables high each cycle, count stays 8, both pointers advance by 3 with wrap.
REQ-037 From empty, wr_req and rd_req together -> fifo_renable=0, fifo_wenable=1, underflow_err=1, count=1.
REQ-038 With count=5, assert areset between clock edges -> count=0, fifo_empty=1 and pointers=0 immediately, without waiting for an edge.
REQ-039 OSTD_NUM=6: 10 pushes interleaved with 10 pops -> pointers wrap 5 to 0, never reach 6 or 7, and final count=0.
